alu_operand_loader: RTL
=======================

# alu_operand_loader

Sequential front end for the 32-bit ALU. It assembles operands A and B byte by byte from the 8-bit data switches, then issues one ALU operation and latches the result and flags into hold registers. It writes into the ALU path rather than reading out of it: the LED byte selector reads a 32-bit result out in byte slices, and this block builds 32-bit operands from byte slices going in. It sits between the debounced board inputs and the ALU instance, and drives the ALU's operand and opcode inputs.

## Interface
Parameters:
- BYTES, 4, bytes per operand (fixed for 32-bit operands; not meant to be changed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SW  in  8  data byte from switches.
- LOAD  in  1  single-cycle strobe that accepts SW (already debounced and edge-detected upstream).
- CLR  in  1  synchronous abort; restarts operand entry.
- ALU_OP  in  3  operation select, sampled on entry to EXEC.
- F  in  32  ALU result (combinational from the ALU).
- ZF  in  1  ALU zero flag.
- OF  in  1  ALU overflow flag.
- A  out  32  operand A register, wired to the ALU.
- B  out  32  operand B register, wired to the ALU.
- OP  out  3  latched opcode, wired to the ALU.
- RES  out  32  captured result.
- RES_ZF  out  1  captured ZF.
- RES_OF  out  1  captured OF.
- DONE  out  1  high while a valid result is held.
- STATE  out  2  current state, for an LED indicator.
- BYTE_IDX  out  2  index of the next byte to be loaded.

## Operation
States: LOAD_A = 0, LOAD_B = 1, EXEC = 2, SHOW = 3.

Transitions:
- LOAD_A: each LOAD writes SW into byte BYTE_IDX of A, then increments BYTE_IDX.
  - The LOAD that writes byte 3 wraps BYTE_IDX to 0 and moves to LOAD_B.
- LOAD_B: same as LOAD_A, but into B; the LOAD that writes byte 3 moves to EXEC.
- EXEC: lasts exactly one cycle.
  - On entry, OP takes ALU_OP.
  - At the end of the EXEC cycle, F, ZF and OF are captured into RES, RES_ZF and RES_OF.
  - Next state is SHOW.
- SHOW: DONE = 1; the result is held.
  - A LOAD in SHOW starts a new entry. It clears A to 0, then writes SW into byte 0 of A, sets BYTE_IDX = 1 and moves to LOAD_A.
  - DONE falls in the same cycle the state leaves SHOW.
  - B and RES are retained until they are overwritten.

Input rules:
- LOAD is ignored in EXEC.
- A LOAD held high for several cycles loads one byte per cycle. Upstream guarantees single-cycle strobes.
- CLR, in any state: A = 0, B = 0, BYTE_IDX = 0, state = LOAD_A, DONE = 0. RES, RES_ZF and RES_OF are retained.
- CLR and LOAD in the same cycle: CLR wins and the byte is discarded.
- ALU_OP changing outside the EXEC entry edge has no effect on OP.

Reset (rst_n low, asynchronous): A = 0, B = 0, OP = 0, RES = 0, RES_ZF = 0, RES_OF = 0, DONE = 0, STATE = LOAD_A, BYTE_IDX = 0. Reset asserted mid-entry discards any partial operand.

## Timing
- Byte write: the byte appears on A or B on the clock edge that samples LOAD = 1.
- Latency from the LOAD of B byte 3:
  - edge 0: state becomes EXEC and OP is latched;
  - edge 1: RES is captured and state becomes SHOW;
  - DONE goes high after edge 1, one cycle after EXEC.
- The ALU path must settle within one clock period, since F is sampled one cycle after OP and B become final.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: LOADER_MSB_FIRST_EN.
- Undefined (default): byte order is LSB first. The first LOAD writes bits [7:0] and the fourth writes [31:24].
- Defined: byte order is MSB first. The first LOAD writes bits [31:24] and the fourth writes [7:0].
- BYTE_IDX still counts 0 to 3 in load order in both modes; only the byte-lane mapping changes.

## Test plan
The bench stubs the ALU as F = A + B (32-bit wrap), ZF = (F == 0), OF = signed add overflow.

- Reset, then load 78, 56, 34, 12, 22, 22, 33, 33 (hex) with ALU_OP = 3'b010 -> A = 0x12345678, B = 0x33332222, OP = 3'b010. RES = 0x4567789A and DONE = 1 exactly 2 cycles after the 8th LOAD; RES_ZF = 0, RES_OF = 0.
- Load A = 0x7FFFFFFF, B = 0x00000001 -> RES = 0x80000000, RES_OF = 1, RES_ZF = 0.
- Load A = 0xFFFFFFFF, B = 0x00000001 -> RES = 0x00000000, RES_ZF = 1, RES_OF = 0.
- After 2 bytes of B, assert CLR together with LOAD -> A = 0, B = 0, STATE = 0, BYTE_IDX = 0. The previous RES is unchanged and the byte is discarded.
- In SHOW, pulse LOAD with SW = 0xAB -> DONE = 0, A = 0x000000AB, BYTE_IDX = 1, STATE = LOAD_A. Pull rst_n low mid-cycle -> every output is at its reset value immediately, without waiting for a clock edge.
- With LOADER_MSB_FIRST_EN defined, load 12, 34, 56, 78 into A -> A = 0x12345678.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Byte-serial operand entry front end for the 32-bit ALU: builds A and B from
// switch bytes, issues one operation, holds the result. Define LOADER_MSB_FIRST_EN for MSB-first lanes.
module alu_operand_loader #(
   parameter int BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           SW,
   input  logic                 LOAD,
   input  logic                 CLR,
   input  logic [2:0]           ALU_OP,
   input  logic [8*BYTES-1:0]   F,
   input  logic                 ZF,
   input  logic                 OF,
   output logic [8*BYTES-1:0]   A,
   output logic [8*BYTES-1:0]   B,
   output logic [2:0]           OP,
   output logic [8*BYTES-1:0]   RES,
   output logic                 RES_ZF,
   output logic                 RES_OF,
   output logic                 DONE,
   output logic [1:0]           STATE,
   output logic [1:0]           BYTE_IDX
);

   localparam int         W        = 8 * BYTES;
   localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

   typedef enum logic [1:0] {
      ST_LOAD_A = 2'd0,
      ST_LOAD_B = 2'd1,
      ST_EXEC   = 2'd2,
      ST_SHOW   = 2'd3
   } state_t;

   state_t       state_q, state_n;
   logic [W-1:0] a_q, a_n;
   logic [W-1:0] b_q, b_n;
   logic [1:0]   idx_q, idx_n;
   logic [2:0]   op_q, op_n;
   logic [W-1:0] res_q;
   logic         res_zf_q, res_of_q;
   logic         done_q;
   logic         capture;

   // Maps the load-order index to the byte lane it fills.
   function automatic int lane_base(input logic [1:0] idx);
`ifdef LOADER_MSB_FIRST_EN
      return 8 * (BYTES - 1 - int'(idx));
`else
      return 8 * int'(idx);
`endif
   endfunction

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_n = state_q;
      a_n     = a_q;
      b_n     = b_q;
      idx_n   = idx_q;
      op_n    = op_q;
      capture = 1'b0;

      if (CLR) begin
         state_n = ST_LOAD_A;
         a_n     = '0;
         b_n     = '0;
         idx_n   = '0;
      end else begin
         unique case (state_q)
            ST_LOAD_A: begin
               if (LOAD) begin
                  a_n[lane_base(idx_q) +: 8] = SW;
                  idx_n = idx_q + 2'd1;
                  if (idx_q == LAST_IDX) state_n = ST_LOAD_B;
               end
            end
            ST_LOAD_B: begin
               if (LOAD) begin
                  b_n[lane_base(idx_q) +: 8] = SW;
                  idx_n = idx_q + 2'd1;
                  if (idx_q == LAST_IDX) begin
                     state_n = ST_EXEC;
                     op_n    = ALU_OP;
                  end
               end
            end
            ST_EXEC: begin
               capture = 1'b1;
               state_n = ST_SHOW;
            end
            ST_SHOW: begin
               // A new entry starts from a clean A with this byte already in lane 0.
               if (LOAD) begin
                  a_n = '0;
                  a_n[lane_base(2'd0) +: 8] = SW;
                  idx_n   = 2'd1;
                  state_n = ST_LOAD_A;
               end
            end
            default: state_n = ST_LOAD_A;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update
   // together from values computed before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOAD_A;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         op_q     <= '0;
         res_q    <= '0;
         res_zf_q <= 1'b0;
         res_of_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         a_q     <= a_n;
         b_q     <= b_n;
         idx_q   <= idx_n;
         op_q    <= op_n;
         done_q  <= (state_n == ST_SHOW);
         if (capture) begin
            res_q    <= F;
            res_zf_q <= ZF;
            res_of_q <= OF;
         end
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign OP       = op_q;
   assign RES      = res_q;
   assign RES_ZF   = res_zf_q;
   assign RES_OF   = res_of_q;
   assign DONE     = done_q;
   assign STATE    = state_q;
   assign BYTE_IDX = idx_q;

endmodule
